ram_arb_2to1: RTL and testbench



---
 rtl/ram_arb_2to1_pkg.sv | 25 ++
 rtl/ram_arb_2to1_rr_arb2.sv | 32 +++
 rtl/ram_arb_2to1.sv | 108 ++++++++++
 tb/tb_ram_arb_2to1.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_2to1_pkg.sv
// Shared types and helpers for the two-master RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;
  localparam int unsigned RAM_DW      = 32;

  typedef logic [$clog2(NUM_MASTERS)-1:0] mst_idx_t;

  // One master's request payload. Widths follow the default 32-bit data path.
  typedef struct packed {
    logic [31:0]         addr;
    logic                we;
    logic [RAM_DW/8-1:0] be;
    logic [RAM_DW-1:0]   wdata;
  } ram_req_t;

  // True when addr falls inside the window that starts at base and spans 2**aw bytes.
  // base is expected to be aligned to the window size.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned aw);
    return ((addr ^ base) >> aw) == '0;
  endfunction

endpackage

// File: rtl/ram_arb_2to1_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, priority flips to the loser.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] gnt
);

  mst_idx_t prio_q;

  // Grant the lone requester, or the preferred one when both ask.
  always_comb begin
    gnt = '0;
    if (&req) begin
      gnt[prio_q] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  // After granting master 0 prefer master 1 and vice versa.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= '0;
    end else if (|gnt) begin
      prio_q <= gnt[0];
    end
  end

endmodule

// File: rtl/ram_arb_2to1.sv
// Two-master arbiter in front of the single-port data RAM wrapper.
// Drives the RAM strobe from the granted master and returns a one-cycle response.
module ram_arb_2to1
  import ram_arb_pkg::*;
#(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH = RAM_DW,
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
  input  logic                                     clk,
  input  logic                                     rst_i,
  input  logic [NUM_MASTERS-1:0]                   m_req_i,
  input  logic [NUM_MASTERS-1:0][31:0]             m_addr_i,
  input  logic [NUM_MASTERS-1:0]                   m_we_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata_i,
  output logic [NUM_MASTERS-1:0]                   m_gnt_o,
  output logic [NUM_MASTERS-1:0]                   m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                    m_rdata_o,
  output logic [NUM_MASTERS-1:0]                   m_err_o,
  output logic                                     ram_en_o,
  output logic [ADDR_WIDTH-1:0]                    ram_addr_o,
  output logic                                     ram_we_o,
  output logic [DATA_WIDTH/8-1:0]                  ram_be_o,
  output logic [DATA_WIDTH-1:0]                    ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]                    ram_rdata_i
);

  logic [NUM_MASTERS-1:0] gnt;
  mst_idx_t               gnt_idx;
  logic                   any_gnt;
  ram_req_t               mst_req [NUM_MASTERS];
  ram_req_t               sel;
  logic                   sel_in_range;

  logic                   rvalid_q;
  mst_idx_t               owner_q;
  logic                   err_q;
  logic                   we_q;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst_i),
    .req (m_req_i),
    .gnt (gnt)
  );

  assign m_gnt_o = gnt;
  assign any_gnt = |gnt;
  assign gnt_idx = gnt[1];

  // Gather each master's payload into a request record.
  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      mst_req[i] = '{addr: m_addr_i[i], we: m_we_i[i], be: m_be_i[i], wdata: m_wdata_i[i]};
    end
  end

  // Select the granted master and check its address against the window.
  always_comb begin
    sel          = mst_req[gnt_idx];
    sel_in_range = in_window(sel.addr, BASE_ADDR, ADDR_WIDTH);
  end

  // RAM strobe: only in-window grants enable the RAM; all zero without a grant.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (any_gnt) begin
      ram_en_o    = sel_in_range;
      ram_we_o    = sel_in_range & sel.we;
      ram_addr_o  = sel.addr[ADDR_WIDTH-1:0];
      ram_be_o    = sel.be;
      ram_wdata_o = sel.wdata;
    end
  end

  // Record the in-flight transaction; it always retires on the next cycle.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      owner_q  <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      rvalid_q <= any_gnt;
      if (any_gnt) begin
        owner_q <= gnt_idx;
        err_q   <= ~sel_in_range;
        we_q    <= sel.we;
      end
    end
  end

  // Route the response to its owner; data only for successful reads.
  always_comb begin
    m_rvalid_o          = '0;
    m_err_o             = '0;
    m_rvalid_o[owner_q] = rvalid_q;
    m_err_o[owner_q]    = rvalid_q & err_q;
    m_rdata_o           = (rvalid_q && !err_q && !we_q) ? ram_rdata_i : '0;
  end

endmodule

// File: tb/tb_ram_arb_2to1.sv
// Self-checking bench for ram_arb_2to1: directed vector table, hand sequences
// for reset and hold corner cases, then random traffic against a reference model.
module tb_ram_arb_2to1;

  localparam int unsigned RAM_SIZE = 32768;
  localparam int unsigned AW       = 15;
  localparam int unsigned DW       = 32;
  localparam logic [31:0] BASE     = 32'h0010_0000;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [1:0]      m_req_i;
  logic [1:0][31:0] m_addr_i;
  logic [1:0]      m_we_i;
  logic [1:0][3:0] m_be_i;
  logic [1:0][31:0] m_wdata_i;
  logic [1:0]      m_gnt_o;
  logic [1:0]      m_rvalid_o;
  logic [31:0]     m_rdata_o;
  logic [1:0]      m_err_o;
  logic            ram_en_o;
  logic [AW-1:0]   ram_addr_o;
  logic            ram_we_o;
  logic [3:0]      ram_be_o;
  logic [31:0]     ram_wdata_o;
  logic [31:0]     ram_rdata_i = '0;

  logic [31:0]     ram_mem [RAM_SIZE/4];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  ram_arb_2to1 #(
    .RAM_SIZE   (RAM_SIZE),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .m_req_i     (m_req_i),
    .m_addr_i    (m_addr_i),
    .m_we_i      (m_we_i),
    .m_be_i      (m_be_i),
    .m_wdata_i   (m_wdata_i),
    .m_gnt_o     (m_gnt_o),
    .m_rvalid_o  (m_rvalid_o),
    .m_rdata_o   (m_rdata_o),
    .m_err_o     (m_err_o),
    .ram_en_o    (ram_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  // Behavioural single-port RAM: read data one cycle after enable.
  initial for (int i = 0; i < RAM_SIZE/4; i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o)
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      ram_rdata_i <= ram_mem[ram_addr_o[AW-1:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] we, input logic [3:0] be0, input logic [3:0] be1,
                       input logic [31:0] d0, input logic [31:0] d1);
    m_req_i   = req;
    m_addr_i  = {a1, a0};
    m_we_i    = we;
    m_be_i    = {be1, be0};
    m_wdata_i = {d1, d0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  we;
    logic [3:0]  be0;
    logic [31:0] d0;
    logic [1:0]  gnt;
    logic        en;
    logic        wen;
    logic [14:0] raddr;
    logic [1:0]  rv;
    logic [1:0]  er;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [1:0] we, input logic [3:0] be0, input logic [31:0] d0,
                              input logic [1:0] gnt, input logic en, input logic wen,
                              input logic [14:0] raddr, input logic [1:0] rv, input logic [1:0] er,
                              input logic [31:0] rd);
    vec_t v;
    v = '{req: req, a0: a0, a1: a1, we: we, be0: be0, d0: d0, gnt: gnt, en: en, wen: wen,
          raddr: raddr, rv: rv, er: er, rd: rd};
    return v;
  endfunction

  vec_t tbl [15];

  // Reference model state for the random phase.
  int unsigned     pref;
  bit              pend_v, pend_err, pend_we;
  int unsigned     pend_own;
  logic [31:0]     pend_rd;
  logic [31:0]     shadow [int unsigned];
  bit              held [2];
  bit              r [2];
  logic [31:0]     pa [2];
  logic            pwe [2];
  logic [3:0]      pbe [2];
  logic [31:0]     pd [2];

  initial begin
    // Directed vectors: each row's response columns come from the row before.
    tbl[0]  = mk(2'b01, 32'h0010_0010, 32'h0, 2'b01, 4'hF, 32'hDEAD_BEEF, 2'b01, 1, 1, 15'h0010, 2'b00, 2'b00, 32'h0);
    tbl[1]  = mk(2'b01, 32'h0010_0010, 32'h0, 2'b00, 4'hF, 32'h0,         2'b01, 1, 0, 15'h0010, 2'b01, 2'b00, 32'h0);
    tbl[2]  = mk(2'b00, 32'h0,         32'h0, 2'b00, 4'h0, 32'h0,         2'b00, 0, 0, 15'h0000, 2'b01, 2'b00, 32'hDEAD_BEEF);
    tbl[3]  = mk(2'b10, 32'h0, 32'h0010_0020, 2'b00, 4'h0, 32'h0,         2'b10, 1, 0, 15'h0020, 2'b00, 2'b00, 32'h0);
    tbl[4]  = mk(2'b11, 32'h0010_0010, 32'h0010_0020, 2'b00, 4'hF, 32'h0, 2'b01, 1, 0, 15'h0010, 2'b10, 2'b00, 32'h0);
    tbl[5]  = mk(2'b11, 32'h0010_0010, 32'h0010_0020, 2'b00, 4'hF, 32'h0, 2'b10, 1, 0, 15'h0020, 2'b01, 2'b00, 32'hDEAD_BEEF);
    tbl[6]  = mk(2'b11, 32'h0010_0010, 32'h0010_0020, 2'b00, 4'hF, 32'h0, 2'b01, 1, 0, 15'h0010, 2'b10, 2'b00, 32'h0);
    tbl[7]  = mk(2'b11, 32'h0010_0010, 32'h0010_0020, 2'b00, 4'hF, 32'h0, 2'b10, 1, 0, 15'h0020, 2'b01, 2'b00, 32'hDEAD_BEEF);
    tbl[8]  = mk(2'b11, 32'h0010_0010, 32'h0010_0020, 2'b00, 4'hF, 32'h0, 2'b01, 1, 0, 15'h0010, 2'b10, 2'b00, 32'h0);
    tbl[9]  = mk(2'b11, 32'h0010_0010, 32'h0010_0020, 2'b00, 4'hF, 32'h0, 2'b10, 1, 0, 15'h0020, 2'b01, 2'b00, 32'hDEAD_BEEF);
    tbl[10] = mk(2'b10, 32'h0, 32'h0020_0000, 2'b00, 4'h0, 32'h0,         2'b10, 0, 0, 15'h0000, 2'b10, 2'b00, 32'h0);
    tbl[11] = mk(2'b01, 32'h0010_7FFC, 32'h0, 2'b01, 4'hF, 32'hFFFF_FFFF, 2'b01, 1, 1, 15'h7FFC, 2'b10, 2'b10, 32'h0);
    tbl[12] = mk(2'b01, 32'h0010_7FFC, 32'h0, 2'b01, 4'h2, 32'h0000_AB00, 2'b01, 1, 1, 15'h7FFC, 2'b01, 2'b00, 32'h0);
    tbl[13] = mk(2'b01, 32'h0010_7FFC, 32'h0, 2'b00, 4'hF, 32'h0,         2'b01, 1, 0, 15'h7FFC, 2'b01, 2'b00, 32'h0);
    tbl[14] = mk(2'b00, 32'h0,         32'h0, 2'b00, 4'h0, 32'h0,         2'b00, 0, 0, 15'h0000, 2'b01, 2'b00, 32'hFFFF_ABFF);

    // Reset and check idle state.
    rst_i = 1'b1;
    drive(2'b00, '0, '0, 2'b00, 4'h0, 4'h0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("reset gnt",    m_gnt_o,    2'b00);
    chk("reset en",     ram_en_o,   1'b0);
    chk("reset rvalid", m_rvalid_o, 2'b00);
    chk("reset err",    m_err_o,    2'b00);
    chk("reset rdata",  m_rdata_o,  32'h0);
    next_cycle();

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].a0, tbl[i].a1, tbl[i].we, tbl[i].be0, 4'hF, tbl[i].d0, 32'h0);
      @(negedge clk);
      chk($sformatf("row%0d gnt", i),    m_gnt_o,    tbl[i].gnt);
      chk($sformatf("row%0d en", i),     ram_en_o,   tbl[i].en);
      chk($sformatf("row%0d we", i),     ram_we_o,   tbl[i].wen);
      if (tbl[i].en) chk($sformatf("row%0d addr", i), ram_addr_o, tbl[i].raddr);
      chk($sformatf("row%0d rvalid", i), m_rvalid_o, tbl[i].rv);
      chk($sformatf("row%0d err", i),    m_err_o,    tbl[i].er);
      chk($sformatf("row%0d rdata", i),  m_rdata_o,  tbl[i].rd);
      next_cycle();
    end

    // Asynchronous reset right after a grant discards the pending response.
    drive(2'b01, 32'h0010_0010, '0, 2'b00, 4'hF, 4'hF, '0, '0);
    @(negedge clk);
    chk("rst-seq gnt", m_gnt_o, 2'b01);
    @(posedge clk);
    #3 rst_i = 1'b1;
    drive(2'b00, '0, '0, 2'b00, 4'h0, 4'h0, '0, '0);
    @(negedge clk);
    chk("rst-seq rvalid in reset", m_rvalid_o, 2'b00);
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst-seq rvalid after", m_rvalid_o, 2'b00);
    next_cycle();

    // First contended request after reset goes to master 0; then hold corner case.
    drive(2'b11, 32'h0010_0044, 32'h0010_0048, 2'b00, 4'hF, 4'hF, '0, '0);
    @(negedge clk);
    chk("post-rst gnt",    m_gnt_o,    2'b01);
    chk("post-rst rvalid", m_rvalid_o, 2'b00);
    chk("post-rst addr",   ram_addr_o, 15'h0044);
    next_cycle();
    @(negedge clk);
    chk("hold m1 gnt",  m_gnt_o,    2'b10);
    chk("hold m1 addr", ram_addr_o, 15'h0048);
    chk("hold rvalid0", m_rvalid_o, 2'b01);
    next_cycle();
    drive(2'b01, 32'h0010_0044, '0, 2'b00, 4'hF, 4'hF, '0, '0);
    @(negedge clk);
    chk("hold m0 gnt",  m_gnt_o,    2'b01);
    chk("hold m0 addr", ram_addr_o, 15'h0044);
    chk("hold rvalid1", m_rvalid_o, 2'b10);
    next_cycle();

    // Random traffic against the reference model.
    rst_i = 1'b1;
    drive(2'b00, '0, '0, 2'b00, 4'h0, 4'h0, '0, '0);
    next_cycle();
    rst_i = 1'b0;
    pref = 0; pend_v = 0; pend_err = 0; pend_we = 0; pend_own = 0; pend_rd = '0;
    held[0] = 0; held[1] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int unsigned win;
      bit          anyg, inw, wr;
      logic [1:0]  exp_gnt;
      int unsigned word;
      for (int m = 0; m < 2; m++) begin
        if (!held[m]) begin
          r[m] = ($urandom_range(0, 9) < 7);
          case ($urandom_range(0, 7))
            0: pa[m] = BASE - 32'(4 * (1 + $urandom_range(0, 15)));
            1: pa[m] = BASE + RAM_SIZE + 32'(4 * $urandom_range(0, 15));
            2: pa[m] = $urandom | 32'h8000_0000;
            default: pa[m] = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 15));
          endcase
          pwe[m] = $urandom_range(0, 1) == 1;
          pbe[m] = 4'($urandom);
          pd[m]  = $urandom;
        end
      end
      drive({r[1], r[0]}, pa[0], pa[1], {pwe[1], pwe[0]}, pbe[0], pbe[1], pd[0], pd[1]);

      anyg    = r[0] | r[1];
      win     = (r[0] && r[1]) ? pref : (r[0] ? 0 : 1);
      exp_gnt = anyg ? 2'(1 << win) : 2'b00;
      inw     = (pa[win] >= BASE) && (pa[win] < BASE + RAM_SIZE);

      @(negedge clk);
      chk("rnd gnt",    m_gnt_o,  exp_gnt);
      chk("rnd en",     ram_en_o, anyg && inw);
      chk("rnd we",     ram_we_o, anyg && inw && pwe[win]);
      if (anyg && inw) begin
        chk("rnd addr",  ram_addr_o,  pa[win] - BASE);
        chk("rnd be",    ram_be_o,    pbe[win]);
        chk("rnd wdata", ram_wdata_o, pd[win]);
      end
      chk("rnd rvalid", m_rvalid_o, pend_v ? 2'(1 << pend_own) : 2'b00);
      chk("rnd err",    m_err_o,    (pend_v && pend_err) ? 2'(1 << pend_own) : 2'b00);
      chk("rnd rdata",  m_rdata_o,  (pend_v && !pend_err && !pend_we) ? pend_rd : 32'h0);

      pend_v = anyg;
      if (anyg) begin
        pend_own = win;
        pend_err = !inw;
        pend_we  = pwe[win];
        wr       = inw && pwe[win];
        word     = (pa[win] - BASE) / 4;
        pend_rd  = (inw && shadow.exists(word)) ? shadow[word] : 32'h0;
        if (wr) begin
          logic [31:0] w;
          w = shadow.exists(word) ? shadow[word] : 32'h0;
          for (int b = 0; b < 4; b++) if (pbe[win][b]) w[8*b +: 8] = pd[win][8*b +: 8];
          shadow[word] = w;
        end
        pref = 1 - win;
      end
      for (int m = 0; m < 2; m++) held[m] = r[m] && !(anyg && win == m);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
